// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants for the register-file write-port controller: default widths,
// FSM state encoding and requester identifiers.
package reg_wb_arbiter_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant generator. req[0]/gnt[0] is requester A, req[1]/gnt[1] is B;
// on contention the requester that did not win last time is granted.
module rr_arb2
    import reg_wb_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // NOTE: every path assigns gnt, so this stays purely combinational (no latch).
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == REQ_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-port controller for the general register file: clears r1..NREG-1 after reset,
// then shares the single write port between requesters A and B with round-robin arbitration.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int INIT_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          reg_we,
    output logic [AW-1:0] reg_waddr,
    output logic [DW-1:0] reg_wdata,
    output logic          init_done
);

    localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);
    localparam logic          ST_RESET  = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic          DONE_RST  = (INIT_EN == 0);

    logic          state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rr_last_q, rr_last_d;
    logic          reg_we_q, reg_we_d;
    logic [AW-1:0] reg_waddr_q, reg_waddr_d;
    logic [DW-1:0] reg_wdata_q, reg_wdata_d;
    logic          init_done_q, init_done_d;

    logic [1:0] gnt;
    logic       live;
    logic       a_fire, b_fire;

    rr_arb2 u_rr_arb2 (
        .req  ({b_valid, a_valid}),
        .last (rr_last_q),
        .gnt  (gnt)
    );

    // Ready is gated by rst_n directly so nothing is accepted while reset is held,
    // even when INIT_EN=0 leaves the FSM in RUN during reset.
    assign live    = rst_n && (state_q == ST_RUN);
    assign a_ready = live && gnt[0];
    assign b_ready = live && gnt[1];
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        init_done_d = init_done_q;

        if (state_q == ST_INIT) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = cnt_q;
            reg_wdata_d = '0;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else if (a_fire) begin
            // Writes to r0 are accepted but never reach the register file.
            reg_we_d    = (a_addr != '0);
            reg_waddr_d = a_addr;
            reg_wdata_d = a_data;
            rr_last_d   = REQ_A;
        end else if (b_fire) begin
            reg_we_d    = (b_addr != '0);
            reg_waddr_d = b_addr;
            reg_wdata_d = b_data;
            rr_last_d   = REQ_B;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= AW'(1);
            rr_last_q   <= REQ_B;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            init_done_q <= DONE_RST;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign init_done = init_done_q;

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Write-port controller for the 32x32 general register file, which has one write port.
- After reset, sequences a clear of registers 1..NREG-1, since the register file has no reset of its own.
- Then shares the single write port between two writeback requesters, A (ALU) and B (load unit), using round-robin arbitration and valid/ready handshakes.
- Drives the register file's we/waddr/wdata from registered outputs.

Parameters:
NREG, 32, number of architectural registers (power of two)
AW, 5, register address width, log2(NREG)
DW, 32, data width
INIT_EN, 1, 1 = run the clear sequence after reset; 0 = go directly to RUN

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; synchronous, active-low
a_valid  input  1  requester A has a write pending
a_addr  input  AW  requester A destination register
a_data  input  DW  requester A write data
a_ready  output  1  requester A transfer accepted this cycle
b_valid  input  1  requester B has a write pending
b_addr  input  AW  requester B destination register
b_data  input  DW  requester B write data
b_ready  output  1  requester B transfer accepted this cycle
reg_we  output  1  register file write enable (registered)
reg_waddr  output  AW  register file write address (registered)
reg_wdata  output  DW  register file write data (registered)
init_done  output  1  clear sequence finished; arbiter is live

Behaviour:
- Reset (rst_n=0 sampled at posedge clk):
  - state = INIT if INIT_EN, else RUN.
  - cnt = 1; rr_last = B, so A wins the first contention.
  - reg_we = 0, reg_waddr = 0, reg_wdata = 0.
  - init_done = 0 if INIT_EN, else 1.
- a_ready/b_ready are combinational: 0 while in reset and in INIT.
- Reset mid-operation (INIT or RUN) aborts immediately; reset values apply on the next edge.
- INIT state, each cycle:
  - reg_we <= 1, reg_waddr <= cnt, reg_wdata <= 0; cnt <= cnt+1.
  - On the edge that issues cnt = NREG-1: state <= RUN, init_done <= 1.
  - Result: with NREG=32, 31 write cycles, and init_done rises together with the final write's outputs.
  - Requests are ignored (not accepted) in INIT; requesters hold valid.
- RUN state, grant logic (combinational):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester opposite rr_last.
  - None valid -> no grant.
  - x_ready = grant_x. At most one ready per cycle.
- RUN state, on an accepted transfer (x_valid & x_ready) at edge N, applied at edge N+1 (1-cycle latency):
  - reg_waddr <= x_addr, reg_wdata <= x_data.
  - reg_we <= 1 if x_addr != 0, else 0. A write to r0 is accepted and discarded.
  - rr_last <= x.
- RUN state, no transfer: reg_we <= 0; reg_waddr and reg_wdata hold their previous values.
- Throughput: one write per cycle. Under continuous contention, grants strictly alternate A, B, A, B...
- A requester must hold valid, addr and data stable until it sees ready. The arbiter does not buffer requests.
- Both requesters targeting the same register: serialized in grant order. The later grant's data is the final register content.
- The state encoding is 1 bit (INIT, RUN). There is no other state, and no illegal-state recovery is needed beyond reset.

Decomposition:
- Shared package: the AW/DW defaults, the state encoding constants (ST_INIT, ST_RUN) and the requester IDs (REQ_A, REQ_B). The core decode unit can reuse these.
- One natural sub-module, rr_arb2: a 2-way round-robin grant generator with inputs req[1:0] and last, and output gnt[1:0]. It is combinational; rr_last is held in the parent.
- The INIT counter, the FSM and the output registers stay in reg_wb_arbiter.

Test Plan:
- Reset release, INIT_EN=1, no requests -> reg_we=1 for exactly 31 cycles with waddr 1..31 and wdata 0; init_done=1 from the cycle of waddr=31; a_ready=b_ready=0 throughout INIT.
- RUN: A alone, addr=5, data=0xDEADBEEF -> a_ready=1 in the same cycle; the next cycle has reg_we=1, waddr=5, wdata=0xDEADBEEF.
- A and B held valid for 4 cycles (A addr 3 data 0x11, B addr 4 data 0x22) -> grants A,B,A,B; reg_waddr sequence 3,4,3,4, each one cycle after its grant.
- B alone, addr=0, data=0x1234 -> b_ready=1; the next cycle has reg_we=0.
- rst_n asserted at INIT cnt=10 -> the next cycle has reg_we=0 and init_done=0; after release, INIT restarts at waddr=1.
- INIT_EN=0 -> init_done=1 out of reset; an A request in the first cycle after release is accepted immediately.
